// File: rtl/hazard_unit_n_pkg.sv
// Shared pipeline definitions for the hazard/forwarding controller.
// Stage indices, bypass select encoding and the shadow-slot bundle.
package hazard_unit_n_pkg;

  localparam int STG_EXE = 1;
  localparam int STG_MEM = 2;
  localparam int STG_WB  = 3;

  localparam int FWD_RF  = 0;

  // Widest register index a slot can track.
  localparam int RW_MAX  = 8;

  typedef logic [RW_MAX-1:0] reg_t;

  typedef struct packed {
    logic v;
    reg_t rw;
    logic ld;
  } slot_t;

  function automatic slot_t bubble();
    return '0;
  endfunction

endpackage

// File: rtl/hazard_match.sv
// Youngest-producer search for one source operand.
// Returns the bypass stage, or a load-use hazard flag.
module hazard_match
  import hazard_unit_n_pkg::*;
#(
  parameter int NSTAGE     = 3,
  parameter int LOAD_READY = 2,
  parameter int SW         = 2
) (
  input  logic          en,
  input  reg_t          op,
  input  slot_t         slots [1:NSTAGE],
  output logic [SW-1:0] sel,
  output logic          haz
);

  // Scan from the youngest slot; first hit decides.
  always_comb begin
    logic found;
    found = 1'b0;
    sel   = SW'(FWD_RF);
    haz   = 1'b0;
    for (int k = 1; k <= NSTAGE; k++) begin
      if (!found && en && slots[k].v &&
          slots[k].rw == op) begin
        found = 1'b1;
        if (slots[k].ld && k < LOAD_READY)
          haz = 1'b1;
        else
          sel = SW'(k);
      end
    end
  end

endmodule

// File: rtl/hazard_unit_n.sv
// Hazard and forwarding controller beside the ID stage.
// Shadows in-flight destinations; drives hold/flush/bypass.
module hazard_unit_n
  import hazard_unit_n_pkg::*;
#(
  parameter int NREG       = 32,
  parameter int NSTAGE     = 3,
  parameter int LOAD_READY = 2,
  parameter int CNTW       = 32,
  localparam int RW        = $clog2(NREG),
  localparam int SW        = $clog2(NSTAGE + 1)
) (
  input  logic            clock,
  input  logic            reset,
  input  logic            id_valid,
  input  logic [RW-1:0]   id_rs,
  input  logic [RW-1:0]   id_rt,
  input  logic            id_use_rs,
  input  logic            id_use_rt,
  input  logic            id_reg_write,
  input  logic [RW-1:0]   id_rw,
  input  logic            id_memtoreg,
  input  logic            br_taken,
  input  logic            ext_stall,
  output logic            stall,
  output logic            flush,
  output logic            issue,
  output logic [SW-1:0]   fwd_a,
  output logic [SW-1:0]   fwd_b,
  output logic [CNTW-1:0] stall_cnt,
  output logic [CNTW-1:0] flush_cnt
);

  slot_t slots [1:NSTAGE];

  logic          en_a;
  logic          en_b;
  logic [SW-1:0] sel_a;
  logic [SW-1:0] sel_b;
  logic          haz_a;
  logic          haz_b;
  logic          hazard;
  slot_t         nxt;

  assign en_a = id_valid & id_use_rs &
                (id_rs != '0);
  assign en_b = id_valid & id_use_rt &
                (id_rt != '0);

  hazard_match #(
    .NSTAGE     (NSTAGE),
    .LOAD_READY (LOAD_READY),
    .SW         (SW)
  ) u_match_a (
    .en    (en_a),
    .op    (reg_t'(id_rs)),
    .slots (slots),
    .sel   (sel_a),
    .haz   (haz_a)
  );

  hazard_match #(
    .NSTAGE     (NSTAGE),
    .LOAD_READY (LOAD_READY),
    .SW         (SW)
  ) u_match_b (
    .en    (en_b),
    .op    (reg_t'(id_rt)),
    .slots (slots),
    .sel   (sel_b),
    .haz   (haz_b)
  );

  assign hazard = haz_a | haz_b;

  // Control outputs; reset forces everything quiet.
  always_comb begin
    stall = ~reset &
            (ext_stall | (hazard & ~br_taken));
    flush = ~reset & br_taken;
    issue = ~reset & id_valid & ~stall &
            ~br_taken & ~ext_stall;
    fwd_a = reset ? SW'(FWD_RF) : sel_a;
    fwd_b = reset ? SW'(FWD_RF) : sel_b;
  end

  // Entry for slot 1: issued instruction or bubble.
  always_comb begin
    nxt = bubble();
    if (issue) begin
      nxt.v  = id_reg_write & (id_rw != '0);
      nxt.rw = reg_t'(id_rw);
      nxt.ld = id_memtoreg;
    end
  end

  // Shadow pipeline advances unless frozen.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      for (int k = 1; k <= NSTAGE; k++)
        slots[k] <= bubble();
    end else if (!ext_stall) begin
      for (int k = NSTAGE; k > STG_EXE; k--)
        slots[k] <= slots[k-1];
      slots[STG_EXE] <= nxt;
    end
  end

  // Saturating stall and flush event counters.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      stall_cnt <= '0;
      flush_cnt <= '0;
    end else begin
      if (hazard & ~br_taken & ~ext_stall &
          ~&stall_cnt)
        stall_cnt <= stall_cnt + CNTW'(1);
      if (br_taken & ~ext_stall & ~&flush_cnt)
        flush_cnt <= flush_cnt + CNTW'(1);
    end
  end

endmodule

// File: tb/tb_hazard_unit_n.sv
// Directed bench for hazard_unit_n.
// Expected outputs queued at drive time, popped at sample.
module tb_hazard_unit_n;

  logic       clock;
  logic       reset;
  logic       id_valid;
  logic [4:0] id_rs;
  logic [4:0] id_rt;
  logic       id_use_rs;
  logic       id_use_rt;
  logic       id_reg_write;
  logic [4:0] id_rw;
  logic       id_memtoreg;
  logic       br_taken;
  logic       ext_stall;
  logic       stall;
  logic       flush;
  logic       issue;
  logic [1:0] fwd_a;
  logic [1:0] fwd_b;
  logic [2:0] stall_cnt;
  logic [2:0] flush_cnt;

  typedef struct {
    logic       st;
    logic       fl;
    logic       is;
    logic [1:0] fa;
    logic [1:0] fb;
    logic [2:0] sc;
    logic [2:0] fc;
  } exp_t;

  exp_t q [$];
  int   n_cmp;
  int   n_bad;

  hazard_unit_n #(
    .NREG       (32),
    .NSTAGE     (3),
    .LOAD_READY (2),
    .CNTW       (3)
  ) dut (
    .clock        (clock),
    .reset        (reset),
    .id_valid     (id_valid),
    .id_rs        (id_rs),
    .id_rt        (id_rt),
    .id_use_rs    (id_use_rs),
    .id_use_rt    (id_use_rt),
    .id_reg_write (id_reg_write),
    .id_rw        (id_rw),
    .id_memtoreg  (id_memtoreg),
    .br_taken     (br_taken),
    .ext_stall    (ext_stall),
    .stall        (stall),
    .flush        (flush),
    .issue        (issue),
    .fwd_a        (fwd_a),
    .fwd_b        (fwd_b),
    .stall_cnt    (stall_cnt),
    .flush_cnt    (flush_cnt)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic drive(
    input logic       vld,
    input logic [4:0] rs,
    input logic       urs,
    input logic [4:0] rt,
    input logic       urt,
    input logic       rwr,
    input logic [4:0] rw,
    input logic       mem,
    input logic       br,
    input logic       ext
  );
    id_valid     = vld;
    id_rs        = rs;
    id_use_rs    = urs;
    id_rt        = rt;
    id_use_rt    = urt;
    id_reg_write = rwr;
    id_rw        = rw;
    id_memtoreg  = mem;
    br_taken     = br;
    ext_stall    = ext;
  endtask

  task automatic push(
    input logic       st,
    input logic       fl,
    input logic       is,
    input logic [1:0] fa,
    input logic [1:0] fb,
    input logic [2:0] sc,
    input logic [2:0] fc
  );
    exp_t e;
    e.st = st; e.fl = fl; e.is = is;
    e.fa = fa; e.fb = fb;
    e.sc = sc; e.fc = fc;
    q.push_back(e);
  endtask

  task automatic cmp(
    input string       tag,
    input logic [31:0] obs,
    input logic [31:0] exp
  );
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s observed=%0h expected=%0h",
             tag, obs, exp);
    end
  endtask

  task automatic check(input string tag);
    exp_t e;
    #1;
    n_cmp++;
    assert (q.size() != 0) else begin
      n_bad++;
      $error("FAIL %s.queue observed=0 expected=1",
             tag);
    end
    if (q.size() != 0) begin
      e = q.pop_front();
      cmp({tag, ".stall"}, 32'(stall), 32'(e.st));
      cmp({tag, ".flush"}, 32'(flush), 32'(e.fl));
      cmp({tag, ".issue"}, 32'(issue), 32'(e.is));
      cmp({tag, ".fwd_a"}, 32'(fwd_a), 32'(e.fa));
      cmp({tag, ".fwd_b"}, 32'(fwd_b), 32'(e.fb));
      cmp({tag, ".scnt"}, 32'(stall_cnt),
          32'(e.sc));
      cmp({tag, ".fcnt"}, 32'(flush_cnt),
          32'(e.fc));
    end
  endtask

  initial begin
    n_cmp = 0;
    n_bad = 0;
    reset = 1'b1;
    // garbage on inputs while reset
    drive(1, 5'd3, 1, 5'd4, 1, 1, 5'd3, 1, 1, 1);
    push(0, 0, 0, 0, 0, 0, 0);
    check("reset");
    @(negedge clock);
    reset = 1'b0;

    // add r3
    drive(1, 0, 0, 0, 0, 1, 5'd3, 0, 0, 0);
    push(0, 0, 1, 0, 0, 0, 0);
    check("add_r3");
    @(negedge clock);
    // consumer of r3 in EXE
    drive(1, 5'd3, 1, 0, 0, 0, 0, 0, 0, 0);
    push(0, 0, 1, 1, 0, 0, 0);
    check("alu_fwd1");
    @(negedge clock);
    // lw r5, r3 now in MEM
    drive(1, 5'd3, 1, 0, 0, 1, 5'd5, 1, 0, 0);
    push(0, 0, 1, 2, 0, 0, 0);
    check("lw_r5_fwd2");
    @(negedge clock);
    // load-use on rt=5, r3 in WB
    drive(1, 5'd3, 1, 5'd5, 1, 1, 5'd6, 0, 0, 0);
    push(1, 0, 0, 3, 0, 0, 0);
    check("ld_use_stall");
    @(negedge clock);
    drive(1, 5'd3, 1, 5'd5, 1, 1, 5'd6, 0, 0, 0);
    push(0, 0, 1, 0, 2, 1, 0);
    check("ld_use_fwd2");
    @(negedge clock);

    // r7 in slots 1 and 3
    drive(1, 0, 0, 0, 0, 1, 5'd7, 0, 0, 0);
    push(0, 0, 1, 0, 0, 1, 0);
    check("w_r7a");
    @(negedge clock);
    drive(1, 0, 0, 0, 0, 1, 5'd9, 0, 0, 0);
    push(0, 0, 1, 0, 0, 1, 0);
    check("w_r9");
    @(negedge clock);
    drive(1, 0, 0, 0, 0, 1, 5'd7, 0, 0, 0);
    push(0, 0, 1, 0, 0, 1, 0);
    check("w_r7b");
    @(negedge clock);
    // youngest wins; also writes r0
    drive(1, 5'd7, 1, 5'd9, 1, 1, 5'd0, 0, 0, 0);
    push(0, 0, 1, 1, 2, 1, 0);
    check("youngest");
    @(negedge clock);
    drive(1, 5'd0, 1, 5'd0, 1, 0, 0, 0, 0, 0);
    push(0, 0, 1, 0, 0, 1, 0);
    check("r0_guard");
    @(negedge clock);

    // branch over a load-use
    drive(1, 0, 0, 0, 0, 1, 5'd5, 1, 0, 0);
    push(0, 0, 1, 0, 0, 1, 0);
    check("lw_r5b");
    @(negedge clock);
    drive(1, 5'd5, 1, 0, 0, 1, 5'd10, 0, 1, 0);
    push(0, 1, 0, 0, 0, 1, 0);
    check("br_hazard");
    @(negedge clock);
    drive(1, 5'd5, 1, 0, 0, 0, 0, 0, 0, 0);
    push(0, 0, 1, 2, 0, 1, 1);
    check("post_br");
    @(negedge clock);

    // freeze with lw r11 in slot 1
    drive(1, 0, 0, 0, 0, 1, 5'd11, 1, 0, 0);
    push(0, 0, 1, 0, 0, 1, 1);
    check("lw_r11");
    @(negedge clock);
    drive(1, 0, 0, 5'd11, 1, 0, 0, 0, 0, 1);
    push(1, 0, 0, 0, 0, 1, 1);
    check("freeze1");
    @(negedge clock);
    drive(1, 0, 0, 5'd11, 1, 0, 0, 0, 0, 1);
    push(1, 0, 0, 0, 0, 1, 1);
    check("freeze2");
    @(negedge clock);
    drive(1, 0, 0, 5'd11, 1, 0, 0, 0, 1, 1);
    push(1, 1, 0, 0, 0, 1, 1);
    check("freeze_br");
    @(negedge clock);
    drive(1, 0, 0, 5'd11, 1, 0, 0, 0, 0, 0);
    push(1, 0, 0, 0, 0, 1, 1);
    check("thaw_held");
    // async reset mid-cycle
    #1;
    reset = 1'b1;
    push(0, 0, 0, 0, 0, 0, 0);
    check("mid_reset");
    @(negedge clock);
    reset = 1'b0;
    drive(1, 0, 0, 5'd11, 1, 0, 0, 0, 0, 0);
    push(0, 0, 1, 0, 0, 0, 0);
    check("post_reset");
    @(negedge clock);

    // flush counter saturation
    for (int i = 0; i < 8; i++) begin
      drive(1, 0, 0, 0, 0, 0, 0, 0, 1, 0);
      push(0, 1, 0, 0, 0, 0,
           3'((i > 7) ? 7 : i));
      check($sformatf("sat%0d", i));
      @(negedge clock);
    end
    drive(1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    push(0, 0, 1, 0, 0, 0, 7);
    check("sat_hold");
    @(negedge clock);
    drive(1, 0, 0, 0, 0, 0, 0, 0, 1, 0);
    push(0, 1, 0, 0, 0, 0, 7);
    check("sat_top");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/hazard_unit_n.md
# hazard_unit_n

Parametrised hazard and forwarding controller for the in-order pipeline. It generalises the fixed EXE/MEM forwarding and single load-use stall to NSTAGE post-decode stages, a configurable load-ready stage, branch flush, external freeze and saturating stall/flush counters. It keeps its own shadow copy of each in-flight instruction's destination. It sits beside the ID stage and drives the PC/IF_ID hold, the IF_ID flush and the operand-bypass mux selects.

## Interface
- NREG, 32, architectural register count; RW = $clog2(NREG) is derived
- NSTAGE, 3, post-ID stages that can hold a pending write (1=EXE, 2=MEM, 3=WB)
- LOAD_READY, 2, first stage index whose result is valid for a load; 1 ≤ LOAD_READY ≤ NSTAGE
- CNTW, 32, performance counter width
- Derived SW = $clog2(NSTAGE+1), forward-select width
- clock  in  1  sole clock, rising edge
- reset  in  1  asynchronous, active-high
- id_valid  in  1  ID holds a real instruction
- id_rs, id_rt  in  RW  source register numbers
- id_use_rs, id_use_rt  in  1  operand is actually read
- id_reg_write  in  1  ID instruction writes the register file
- id_rw  in  RW  destination register number, after rt/rd/31 select
- id_memtoreg  in  1  ID instruction is a load
- br_taken  in  1  taken branch or jump resolved in EXE this cycle
- ext_stall  in  1  freeze the whole pipeline (memory busy)
- stall  out  1  hold PC and IF_ID
- flush  out  1  clear IF_ID to a bubble
- issue  out  1  ID instruction enters EXE at this edge
- fwd_a, fwd_b  out  SW  0 = register file, k = result of stage k
- stall_cnt, flush_cnt  out  CNTW  event counters

## Operation
- Shadow slots k=1..NSTAGE each hold v, rw and ld. Slot k mirrors pipeline stage k.
- Effective dest match for operand r: r≠0, its use bit set, id_valid, and the smallest k with v[k] && rw[k]==r. Only the youngest producer counts.
- Hazard on an operand: a match exists, ld[k]=1 and k < LOAD_READY.
- Forward select: the matched k when there is no hazard, else 0. Select is 0 when there is no match.
- hazard = hazard_a | hazard_b.
- flush = br_taken.
- stall = ext_stall | (hazard & ~br_taken). A flush overrides a load-use stall.
- issue = id_valid & ~stall & ~br_taken & ~ext_stall.
- Shift rule, applied at each edge when ext_stall=0:
  - slot k+1 ← slot k;
  - slot 1 ← {id_reg_write & id_rw≠0, id_rw, id_memtoreg} if issue, else a bubble (v=0).
- When ext_stall=1, all slots hold.
- Counter updates:
  - stall_cnt increments on each cycle with hazard & ~br_taken & ~ext_stall;
  - flush_cnt increments on each br_taken & ~ext_stall;
  - both saturate at all-ones.
- Writes to r0 are never tracked. r0 never forwards and never stalls.

## Timing
- The fwd_*, stall, flush and issue outputs are combinational from the ID inputs and the slot registers, within the same cycle.
- Slots update at the rising clock edge.
- Reset (asynchronous) clears all v, rw, ld and both counters. While reset is high, stall=0, flush=0, issue=0 and fwd_a=fwd_b=0 regardless of inputs.
- Release from reset takes effect at the first rising edge after deassertion.
- Load-use with the defaults: the load sits in slot 1 while the consumer is in ID, so stall=1 for exactly 1 cycle. The next cycle has the load in slot 2, giving fwd=2.
- General load penalty is LOAD_READY−1 cycles.
- ALU producer: no stall, fwd=1.
- br_taken together with a hazard: flush=1, stall=0, and slot 1 takes a bubble (the ID instruction is squashed).
- br_taken together with ext_stall: flush=1 and the slots hold. The datapath retries flush on the next cycle, since br_taken persists.
- Reset asserted mid-stall: the stall drops immediately and all slots become bubbles.

## Structure
- A shared pipeline package holds:
  - the stage index constants (STG_EXE=1, STG_MEM=2, STG_WB=3);
  - the FWD_RF=0 select encoding;
  - the shadow-slot struct {v, rw, ld}.
- One sub-module, hazard_match, handles one operand's youngest-match search. It takes an operand and the slot vector, and returns a select and a hazard flag. It is instantiated twice.
- The counters stay inline.

## Test plan
- ALU dependency: add r3 enters slot 1, ID reads rs=3 → fwd_a=1, stall=0, issue=1.
- Load-use: lw r5 in slot 1, ID uses rt=5 → stall=1 for one cycle and stall_cnt=1. The next cycle gives fwd_b=2 with stall=0.
- Youngest wins: r7 written in slots 1 and 3, ID reads r7 → fwd_a=1.
- r0 guard: id_rw=0 with id_reg_write=1, then ID reads r0 → fwd=0, stall=0.
- Branch during hazard: lw r5 in slot 1, ID uses r5, br_taken=1 → flush=1, stall=0, next slot 1 v=0, flush_cnt=1.
- Freeze and reset: ext_stall=1 for 3 cycles → slots unchanged and stall=1. Then assert reset asynchronously mid-cycle → all outputs 0 before the next edge.
